pipe_exe_to_mem: RTL and testbench

Execute-to-memory pipeline register for the reverb processor core. It sits directly downstream of the decode-to-execute register and the ALU. It captures the ALU result, store data, destination register and control bits at the end of the execute stage, and presents them to the data-memory stage. It supports stall (hold) and flush (bubble), and generates M-stage forwarding match signals back to the execute-stage operand muxes.

---
 rtl/pipe_exe_to_mem_if.sv | 62 ++++++
 rtl/pipe_exe_to_mem.sv | 106 ++++++++++
 tb/tb_pipe_exe_to_mem.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_exe_to_mem_if.sv
// Execute-to-memory pipeline bus.
// Carries E-stage inputs (control, data, destination, source registers),
// pipeline controls (stallM, flushM, perfClr) and the registered M-stage view
// (control, data, destination, forwarding/load-use matches, perf counters).
// modport slave  : the pipeline register itself
// modport master : the surrounding core (execute stage, hazard unit)
interface pipe_exe_to_mem_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 4
);
   localparam int unsigned CNT_W = 16;

   // pipeline control
   logic              stallM;
   logic              flushM;
   logic              perfClr;

   // execute-stage payload
   logic              validE;
   logic              regWriteE;
   logic              memWriteE;
   logic              memToRegE;
   logic [DATA_W-1:0] aluResultE;
   logic [DATA_W-1:0] writeDataE;
   logic [REG_W-1:0]  WA3E;
   logic [REG_W-1:0]  RA1E;
   logic [REG_W-1:0]  RA2E;

   // memory-stage view
   logic              validM;
   logic              regWriteM;
   logic              memWriteM;
   logic              memToRegM;
   logic [DATA_W-1:0] aluResultM;
   logic [DATA_W-1:0] writeDataM;
   logic [REG_W-1:0]  WA3M;
   logic              fwdAM;
   logic              fwdBM;
   logic              loadUseM;
   logic [CNT_W-1:0]  perfStallCnt;
   logic [CNT_W-1:0]  perfBubbleCnt;

   modport master (
      output stallM, flushM, perfClr,
      output validE, regWriteE, memWriteE, memToRegE,
      output aluResultE, writeDataE, WA3E, RA1E, RA2E,
      input  validM, regWriteM, memWriteM, memToRegM,
      input  aluResultM, writeDataM, WA3M,
      input  fwdAM, fwdBM, loadUseM,
      input  perfStallCnt, perfBubbleCnt
   );

   modport slave (
      input  stallM, flushM, perfClr,
      input  validE, regWriteE, memWriteE, memToRegE,
      input  aluResultE, writeDataE, WA3E, RA1E, RA2E,
      output validM, regWriteM, memWriteM, memToRegM,
      output aluResultM, writeDataM, WA3M,
      output fwdAM, fwdBM, loadUseM,
      output perfStallCnt, perfBubbleCnt
   );
endinterface

// File: rtl/pipe_exe_to_mem.sv
// Execute-to-memory pipeline register for the reverb processor core.
// Captures ALU result, store data, destination and control bits at the end of
// execute; supports stall (hold) and flush (bubble); produces M-stage
// forwarding matches and a load-use indication for the execute stage.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - pipe_exe_to_mem_if.slave (E inputs, stall/flush, M outputs,
//          fwdAM/fwdBM/loadUseM combinational, perf counters)
// Optional feature: define PIPE_EM_PERF_EN to build the stall/bubble
// performance counters; otherwise they read as zero and perfClr is ignored.
module pipe_exe_to_mem #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 4
) (
   input logic              clk,
   input logic              rst,
   pipe_exe_to_mem_if.slave bus
);
   localparam int unsigned CNT_W = 16;
   localparam logic [REG_W-1:0] PC_REG = {REG_W{1'b1}};

   logic              valid_q;
   logic              reg_write_q;
   logic              mem_write_q;
   logic              mem_to_reg_q;
   logic [DATA_W-1:0] alu_result_q;
   logic [DATA_W-1:0] write_data_q;
   logic [REG_W-1:0]  wa3_q;

   // M-stage registers: reset > flush (bubble) > stall (hold) > load
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         alu_result_q <= '0;
         write_data_q <= '0;
         wa3_q        <= '0;
      end else if (bus.flushM) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         alu_result_q <= '0;
         write_data_q <= '0;
         wa3_q        <= '0;
      end else if (!bus.stallM) begin
         // control bits are qualified so an empty E slot never writes
         valid_q      <= bus.validE;
         reg_write_q  <= bus.regWriteE & bus.validE;
         mem_write_q  <= bus.memWriteE & bus.validE;
         mem_to_reg_q <= bus.memToRegE & bus.validE;
         alu_result_q <= bus.aluResultE;
         write_data_q <= bus.writeDataE;
         wa3_q        <= bus.WA3E;
      end
   end

   assign bus.validM     = valid_q;
   assign bus.regWriteM  = reg_write_q;
   assign bus.memWriteM  = mem_write_q;
   assign bus.memToRegM  = mem_to_reg_q;
   assign bus.aluResultM = alu_result_q;
   assign bus.writeDataM = write_data_q;
   assign bus.WA3M       = wa3_q;

   // Forwarding matches; R15 writes go through the PC path, never forwarded
   assign bus.fwdAM = valid_q & reg_write_q & (wa3_q == bus.RA1E) & (wa3_q != PC_REG);
   assign bus.fwdBM = valid_q & reg_write_q & (wa3_q == bus.RA2E) & (wa3_q != PC_REG);

   // Load in M feeding either source of E: the hazard unit stalls on this
   assign bus.loadUseM = valid_q & mem_to_reg_q &
                         ((wa3_q == bus.RA1E) | (wa3_q == bus.RA2E));

`ifdef PIPE_EM_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] bubble_cnt;

   // Saturating performance counters; clear wins over increment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else if (bus.perfClr) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (bus.stallM && !bus.flushM && valid_q && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (bus.flushM && (bubble_cnt != {CNT_W{1'b1}}))
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

   assign bus.perfStallCnt  = stall_cnt;
   assign bus.perfBubbleCnt = bubble_cnt;
`else
   logic unused_perf_clr;
   assign unused_perf_clr   = bus.perfClr;
   assign bus.perfStallCnt  = '0;
   assign bus.perfBubbleCnt = '0;
`endif

endmodule

// File: tb/tb_pipe_exe_to_mem.sv
// Directed self-checking bench for pipe_exe_to_mem.
module tb_pipe_exe_to_mem;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 4;
`ifdef PIPE_EM_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;

   pipe_exe_to_mem_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

   pipe_exe_to_mem #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_e(input logic v, input logic rw, input logic mw, input logic mr,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] wa);
      bus.validE     = v;
      bus.regWriteE  = rw;
      bus.memWriteE  = mw;
      bus.memToRegE  = mr;
      bus.aluResultE = alu;
      bus.writeDataE = wd;
      bus.WA3E       = wa;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst = 1'b0;
      bus.stallM = 1'b0;
      bus.flushM = 1'b0;
      bus.perfClr = 1'b0;
      bus.RA1E = 4'd0;
      bus.RA2E = 4'd0;
      // inputs active during reset must not leak through
      set_e(1'b1, 1'b1, 1'b1, 1'b1, 32'd99, 32'd98, 4'd0);

      tick();
      tick();
      chk("rst_validM",     32'(bus.validM), 32'd0);
      chk("rst_regWriteM",  32'(bus.regWriteM), 32'd0);
      chk("rst_memWriteM",  32'(bus.memWriteM), 32'd0);
      chk("rst_aluResultM", bus.aluResultM, 32'd0);
      chk("rst_writeDataM", bus.writeDataM, 32'd0);
      chk("rst_stallcnt",   32'(bus.perfStallCnt), 32'd0);
      chk("rst_bubblecnt",  32'(bus.perfBubbleCnt), 32'd0);

      // normal load
      rst = 1'b1;
      set_e(1'b1, 1'b1, 1'b0, 1'b0, 32'd22, 32'd7, 4'd3);
      tick();
      chk("load_aluResultM", bus.aluResultM, 32'd22);
      chk("load_writeDataM", bus.writeDataM, 32'd7);
      chk("load_WA3M",       32'(bus.WA3M), 32'd3);
      chk("load_regWriteM",  32'(bus.regWriteM), 32'd1);
      chk("load_validM",     32'(bus.validM), 32'd1);
      chk("load_memWriteM",  32'(bus.memWriteM), 32'd0);

      // invalid slot suppresses all control bits, data still copied
      set_e(1'b0, 1'b1, 1'b1, 1'b1, 32'd33, 32'd44, 4'd9);
      tick();
      chk("inv_regWriteM",  32'(bus.regWriteM), 32'd0);
      chk("inv_memWriteM",  32'(bus.memWriteM), 32'd0);
      chk("inv_memToRegM",  32'(bus.memToRegM), 32'd0);
      chk("inv_validM",     32'(bus.validM), 32'd0);
      chk("inv_aluResultM", bus.aluResultM, 32'd33);

      // stall holds, then flush beats stall
      set_e(1'b1, 1'b1, 1'b1, 1'b0, 32'd15, 32'd5, 4'd6);
      tick();
      chk("pre_stall_alu", bus.aluResultM, 32'd15);
      bus.stallM = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.aluResultE = 32'd16 + 32'(i);
         tick();
         chk("stall_hold_alu", bus.aluResultM, 32'd15);
      end
      chk("stall_hold_memWriteM", 32'(bus.memWriteM), 32'd1);
      bus.flushM = 1'b1;
      tick();
      chk("flush_validM",     32'(bus.validM), 32'd0);
      chk("flush_aluResultM", bus.aluResultM, 32'd0);
      chk("flush_writeDataM", bus.writeDataM, 32'd0);
      chk("flush_WA3M",       32'(bus.WA3M), 32'd0);
      chk("flush_memWriteM",  32'(bus.memWriteM), 32'd0);
      // stall after flush keeps the bubble
      bus.flushM = 1'b0;
      bus.aluResultE = 32'd50;
      tick();
      chk("stall_bubble_validM", 32'(bus.validM), 32'd0);
      chk("stall_bubble_alu",    bus.aluResultM, 32'd0);
      // back-to-back flushes keep the bubble
      bus.stallM = 1'b0;
      bus.flushM = 1'b1;
      tick();
      tick();
      chk("flush2_validM", 32'(bus.validM), 32'd0);
      chk("flush2_alu",    bus.aluResultM, 32'd0);
      bus.flushM = 1'b0;

      // forwarding
      set_e(1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 32'd2, 4'd5);
      tick();
      bus.RA1E = 4'd5;
      bus.RA2E = 4'd2;
      #1;
      chk("fwdA_hit",  32'(bus.fwdAM), 32'd1);
      chk("fwdB_miss", 32'(bus.fwdBM), 32'd0);
      chk("lu_noload", 32'(bus.loadUseM), 32'd0);
      bus.RA1E = 4'd2;
      bus.RA2E = 4'd5;
      #1;
      chk("fwdA_miss", 32'(bus.fwdAM), 32'd0);
      chk("fwdB_hit",  32'(bus.fwdBM), 32'd1);
      set_e(1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 32'd2, 4'd15);
      tick();
      bus.RA1E = 4'd15;
      bus.RA2E = 4'd15;
      #1;
      chk("fwdA_r15", 32'(bus.fwdAM), 32'd0);
      chk("fwdB_r15", 32'(bus.fwdBM), 32'd0);
      set_e(1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2, 4'd6);
      tick();
      bus.RA1E = 4'd6;
      #1;
      chk("fwdA_noregwrite", 32'(bus.fwdAM), 32'd0);

      // load-use
      set_e(1'b1, 1'b1, 1'b0, 1'b1, 32'd100, 32'd0, 4'd4);
      tick();
      bus.RA1E = 4'd0;
      bus.RA2E = 4'd4;
      #1;
      chk("loaduse_hit", 32'(bus.loadUseM), 32'd1);
      chk("loaduse_fwdB", 32'(bus.fwdBM), 32'd1);
      bus.RA1E = 4'd4;
      bus.RA2E = 4'd1;
      #1;
      chk("loaduse_hit_ra1", 32'(bus.loadUseM), 32'd1);
      bus.flushM = 1'b1;
      tick();
      chk("loaduse_flushed", 32'(bus.loadUseM), 32'd0);
      bus.flushM = 1'b0;

      // async reset during a stall clears immediately
      set_e(1'b1, 1'b1, 1'b0, 1'b0, 32'd77, 32'd0, 4'd2);
      tick();
      chk("pre_rst_alu", bus.aluResultM, 32'd77);
      bus.stallM = 1'b1;
      rst = 1'b0;
      #1;
      chk("async_rst_validM", 32'(bus.validM), 32'd0);
      chk("async_rst_alu",    bus.aluResultM, 32'd0);
      tick();
      rst = 1'b1;
      bus.stallM = 1'b0;
      bus.aluResultE = 32'd88;
      tick();
      chk("post_rst_load", bus.aluResultM, 32'd88);
      chk("post_rst_validM", 32'(bus.validM), 32'd1);

      // performance counters
      bus.perfClr = 1'b1;
      tick();
      bus.perfClr = 1'b0;
      chk("clr0_stall",  32'(bus.perfStallCnt), 32'd0);
      chk("clr0_bubble", 32'(bus.perfBubbleCnt), 32'd0);
      bus.stallM = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("cnt_stall5", 32'(bus.perfStallCnt), PERF ? 32'd5 : 32'd0);
      chk("cnt_bubble0", 32'(bus.perfBubbleCnt), 32'd0);
      // flush after stall discards the held instruction; not a stall cycle
      bus.flushM = 1'b1;
      tick();
      chk("flush_after_stall_validM", 32'(bus.validM), 32'd0);
      bus.stallM = 1'b0;
      tick();
      chk("cnt_stall_kept", 32'(bus.perfStallCnt), PERF ? 32'd5 : 32'd0);
      chk("cnt_bubble2",    32'(bus.perfBubbleCnt), PERF ? 32'd2 : 32'd0);
      // stall on an empty M slot is not counted
      bus.flushM = 1'b0;
      bus.stallM = 1'b1;
      tick();
      chk("cnt_stall_empty", 32'(bus.perfStallCnt), PERF ? 32'd5 : 32'd0);
      // clear wins over simultaneous increments
      bus.flushM = 1'b1;
      bus.perfClr = 1'b1;
      tick();
      bus.perfClr = 1'b0;
      bus.flushM = 1'b0;
      bus.stallM = 1'b0;
      chk("clr_stall",  32'(bus.perfStallCnt), 32'd0);
      chk("clr_bubble", 32'(bus.perfBubbleCnt), 32'd0);

      // saturation
      set_e(1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 32'd0, 4'd1);
      tick();
      bus.stallM = 1'b1;
      for (int i = 0; i < (PERF ? 70000 : 10); i++) tick();
      chk("cnt_sat", 32'(bus.perfStallCnt), PERF ? 32'h0000FFFF : 32'd0);
      chk("sat_hold_alu", bus.aluResultM, 32'd3);
      bus.stallM = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
